// File: rtl/ram_pkg.sv
// Shared constants and word type for the dual-port RAM.
// Pulled in by the top level and its read mux.
package ram_pkg;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DEPTH  = 16;

  typedef logic [RAM_DATA_W-1:0] ram_word_t;
endpackage

// File: rtl/ram_dual_port_rd_mux.sv
// Read-address decode with write-first bypass.
// Out-of-range reads return zero.
module ram_dual_port_rd_mux
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic                         we,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            rd_data
);
  logic r_ok;
  logic hit;

  always_comb begin
    r_ok    = 32'(raddr) < DEPTH;
    hit     = we && (waddr == raddr);
    rd_data = '0;
    unique case (1'b1)
      !r_ok:   rd_data = '0;
      hit:     rd_data = data_in;
      default: rd_data = mem[raddr];
    endcase
  end
endmodule

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port, one registered read port.
// Async reset clears the storage and the output register.
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]            data_out_q, data_out_d;
  logic [DATA_W-1:0]            rd_data;
  logic                         w_ok;

  ram_dual_port_rd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_mux (
    .mem     (mem_q),
    .raddr   (raddr),
    .waddr   (waddr),
    .we      (we),
    .data_in (data_in),
    .rd_data (rd_data)
  );

  always_comb begin
    w_ok  = 32'(waddr) < DEPTH;
    mem_d = mem_q;
    if (we && w_ok)
      mem_d[waddr] = data_in;
    data_out_d = re ? rd_data : data_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '0;
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
endmodule

// File: tb/tb_ram_dual_port.sv
// Randomised and directed checks of ram_dual_port
// against an array-based reference model.
module tb_ram_dual_port;
  import ram_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      waddr = '0;
  logic [3:0]      raddr = '0;
  logic            we = 1'b0;
  logic            re = 1'b0;
  ram_word_t       data_in = '0;
  ram_word_t       data_out;

  ram_word_t ref_mem [16];
  ram_word_t ref_out;
  int        n_chk = 0;
  int        n_ok  = 0;

  ram_dual_port dut (
    .clk      (clk),
    .rst      (rst),
    .waddr    (waddr),
    .raddr    (raddr),
    .we       (we),
    .re       (re),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic ref_reset();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    ref_out = '0;
  endtask

  // Drive one cycle at negedge, apply model at posedge, check at next negedge.
  task automatic cyc(input string tag, input logic w, input logic r,
                     input logic [3:0] wa, input logic [3:0] ra,
                     input logic [7:0] d);
    we = w; re = r; waddr = wa; raddr = ra; data_in = d;
    @(posedge clk);
    if (r) ref_out = (w && wa == ra) ? d : ref_mem[ra];
    if (w) ref_mem[wa] = d;
    @(negedge clk);
    check(tag, data_out, ref_out);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we = 1'b0; re = 1'b0;
    #1;
    ref_reset();
    check("rst_async", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    ref_reset();
    @(negedge clk);
    check("rst_init", data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_pulse", data_out, 8'h00);
    for (int i = 0; i < 16; i++)
      cyc("rst_read", 1'b0, 1'b1, 4'd0, 4'(i), 8'h00);

    cyc("wr3", 1'b1, 1'b0, 4'd3, 4'd0, 8'hA5);
    cyc("rd3", 1'b0, 1'b1, 4'd0, 4'd3, 8'h00);
    check("rd3_val", data_out, 8'hA5);

    for (int i = 0; i < 3; i++)
      cyc("hold", 1'b0, 1'b0, 4'd1, 4'd7, 8'hFF);
    check("hold_val", data_out, 8'hA5);

    cyc("wr5", 1'b1, 1'b0, 4'd5, 4'd0, 8'h11);
    cyc("coll", 1'b1, 1'b1, 4'd5, 4'd5, 8'h7E);
    check("coll_val", data_out, 8'h7E);
    cyc("rd5", 1'b0, 1'b1, 4'd0, 4'd5, 8'h00);
    check("rd5_val", data_out, 8'h7E);

    cyc("wr2", 1'b1, 1'b0, 4'd2, 4'd0, 8'h33);
    cyc("conc", 1'b1, 1'b1, 4'd9, 4'd2, 8'hC4);
    check("conc_val", data_out, 8'h33);
    cyc("rd9", 1'b0, 1'b1, 4'd0, 4'd9, 8'h00);
    check("rd9_val", data_out, 8'hC4);

    cyc("rd3b", 1'b0, 1'b1, 4'd0, 4'd3, 8'h00);
    cyc("hold2", 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
    check("hold2_val", data_out, 8'hA5);
    #2;
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc("clr_read", 1'b0, 1'b1, 4'd0, 4'(i), 8'h00);

    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      cyc("sweep_wr", 1'b1, 1'b0, 4'(i), 4'd0, b);
      cyc("sweep_rd", 1'b1, 1'b1, 4'(i), 4'(i), b);
      check("sweep_val", data_out, b);
    end

    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom), 1'($urandom),
          4'($urandom), 4'($urandom), 8'($urandom));

    // Reset asserted between edges while reads are in flight.
    we = 1'b1; re = 1'b1; waddr = 4'd4; raddr = 4'd4; data_in = 8'h5A;
    #2;
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc("post_rst", 1'b0, 1'b1, 4'd0, 4'(i), 8'h00);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
